pll_reset_ctrl: RTL

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset supervisor: pulses the PLL reset, waits for a settled lock, then
// releases the downstream channel resets one by one and watches for lock loss.
module pll_reset_ctrl #(
  parameter int         NCH          = 4,
  parameter int         RST_PULSE    = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         SETTLE       = 256,
  parameter int         STAGGER      = 16,
  parameter int         CNT_W        = 8,
  parameter logic [6:0] ODIV_DEFAULT = 7'd13
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             pll_lock_i,
  input  logic             cfg_req_i,
  input  logic [6:0]       cfg_odiv_i,
  output logic             pll_reset_o,
  output logic [6:0]       odsel_o,
  output logic             cfg_ack_o,
  output logic [NCH-1:0]   rst_n_out_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o,
  output logic [CNT_W-1:0] retry_cnt_o
);

  // One shared timer covers every timed phase, so it is sized for the longest.
  localparam int MAX_A   = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_B   = (SETTLE > STAGGER) ? SETTLE : STAGGER;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_CNT + 1);
  localparam logic [NCH-1:0]   CH0     = NCH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e           state_q;
  logic [1:0]       lockSync_q;
  logic [TW-1:0]    tmr_q;
  logic             pllReset_q;
  logic             cfgAck_q;
  logic             locked_q;
  logic [6:0]       odsel_q;
  logic [NCH-1:0]   rstN_q;
  logic [CNT_W-1:0] lossCnt_q;
  logic [CNT_W-1:0] lossCnt_d;
  logic [CNT_W-1:0] retryCnt_q;
  logic [CNT_W-1:0] retryCnt_d;
  logic             lock;
  logic             acceptCfg;
  logic             lockLoss;

  always_comb begin
    lock       = lockSync_q[1];
    acceptCfg  = cfg_req_i && ((state_q == ST_RUN) || (state_q == ST_WAIT_LOCK));
    lockLoss   = !lock && ((state_q == ST_RELEASE) || (state_q == ST_RUN));
    lossCnt_d  = (lossCnt_q == CNT_MAX) ? lossCnt_q : lossCnt_q + CNT_W'(1);
    retryCnt_d = (retryCnt_q == CNT_MAX) ? retryCnt_q : retryCnt_q + CNT_W'(1);
  end

  // A reconfiguration request outranks lock loss, but the loss is still counted.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_RESET_PLL;
      lockSync_q <= '0;
      tmr_q      <= '0;
      pllReset_q <= 1'b1;
      cfgAck_q   <= 1'b0;
      locked_q   <= 1'b0;
      odsel_q    <= ODIV_DEFAULT;
      rstN_q     <= '0;
      lossCnt_q  <= '0;
      retryCnt_q <= '0;
    end else begin
      lockSync_q <= {lockSync_q[0], pll_lock_i};
      cfgAck_q   <= 1'b0;
      if (lockLoss) begin
        lossCnt_q <= lossCnt_d;
      end
      if (acceptCfg) begin
        cfgAck_q   <= 1'b1;
        odsel_q    <= cfg_odiv_i;
        rstN_q     <= '0;
        locked_q   <= 1'b0;
        pllReset_q <= 1'b1;
        tmr_q      <= '0;
        state_q    <= ST_RESET_PLL;
      end else if (lockLoss) begin
        rstN_q   <= '0;
        locked_q <= 1'b0;
        tmr_q    <= '0;
        state_q  <= ST_WAIT_LOCK;
      end else begin
        case (state_q)
          ST_RESET_PLL: begin
            pllReset_q <= 1'b1;
            rstN_q     <= '0;
            locked_q   <= 1'b0;
            if (tmr_q == TW'(RST_PULSE - 1)) begin
              pllReset_q <= 1'b0;
              tmr_q      <= '0;
              state_q    <= ST_WAIT_LOCK;
            end else begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
          ST_WAIT_LOCK: begin
            if (lock) begin
              tmr_q   <= '0;
              state_q <= ST_SETTLE;
            end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
              retryCnt_q <= retryCnt_d;
              pllReset_q <= 1'b1;
              tmr_q      <= '0;
              state_q    <= ST_RESET_PLL;
            end else begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
          ST_SETTLE: begin
            if (!lock) begin
              tmr_q   <= '0;
              state_q <= ST_WAIT_LOCK;
            end else if (tmr_q == TW'(SETTLE - 1)) begin
              rstN_q  <= CH0;
              tmr_q   <= '0;
              state_q <= ST_RELEASE;
            end else begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
          ST_RELEASE: begin
            if (rstN_q[NCH-1]) begin
              locked_q <= 1'b1;
              state_q  <= ST_RUN;
            end else if (tmr_q == TW'(STAGGER - 1)) begin
              rstN_q <= (rstN_q << 1) | CH0;
              tmr_q  <= '0;
            end else begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
          ST_RUN: begin
            locked_q <= 1'b1;
          end
          default: begin
            pllReset_q <= 1'b1;
            rstN_q     <= '0;
            locked_q   <= 1'b0;
            tmr_q      <= '0;
            state_q    <= ST_RESET_PLL;
          end
        endcase
      end
    end
  end

  assign pll_reset_o     = pllReset_q;
  assign odsel_o         = odsel_q;
  assign cfg_ack_o       = cfgAck_q;
  assign rst_n_out_o     = rstN_q;
  assign locked_o        = locked_q;
  assign lock_loss_cnt_o = lossCnt_q;
  assign retry_cnt_o     = retryCnt_q;

endmodule
